// File: rtl/mac_job_dispatcher_if.sv
// Core/MAC-FSM handshake bundle for mac_job_dispatcher; names are from the dispatcher's side.
// Watchdog signals exist only when MAC_JOB_DISPATCHER_WATCHDOG_EN is defined.
interface mac_job_dispatcher_if #(
    parameter int N_CORES  = 2,
    parameter int ID_WIDTH = 8
);
    localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [N_CORES-1:0]  req_i;
    logic [N_CORES-1:0]  gnt_o;
    logic [ID_WIDTH-1:0] job_id_o;
    logic                start_o;
    logic                start_ready_i;
    logic [CW-1:0]       cur_core_o;
    logic [ID_WIDTH-1:0] cur_id_o;
    logic                done_i;
    logic [N_CORES-1:0]  evt_o;
    logic                busy_o;
    logic                full_o;
`ifdef MAC_JOB_DISPATCHER_WATCHDOG_EN
    logic [31:0]         wdt_limit_i;
    logic                abort_o;

    modport master (
        output req_i, start_ready_i, done_i, wdt_limit_i,
        input  gnt_o, job_id_o, start_o, cur_core_o, cur_id_o, evt_o, busy_o, full_o, abort_o
    );
    modport slave (
        input  req_i, start_ready_i, done_i, wdt_limit_i,
        output gnt_o, job_id_o, start_o, cur_core_o, cur_id_o, evt_o, busy_o, full_o, abort_o
    );
`else
    modport master (
        output req_i, start_ready_i, done_i,
        input  gnt_o, job_id_o, start_o, cur_core_o, cur_id_o, evt_o, busy_o, full_o
    );
    modport slave (
        input  req_i, start_ready_i, done_i,
        output gnt_o, job_id_o, start_o, cur_core_o, cur_id_o, evt_o, busy_o, full_o
    );
`endif
endinterface

// File: rtl/mac_job_dispatcher.sv
// Round-robin job dispatcher feeding a MAC FSM; optional watchdog via MAC_JOB_DISPATCHER_WATCHDOG_EN.
// Grant->start_o in 2 cycles from idle; start_o holds until start_ready_i; grants stall while full.
module mac_job_dispatcher #(
    parameter int N_CORES  = 2,
    parameter int N_JOBS   = 2,
    parameter int ID_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    mac_job_dispatcher_if.slave bus
);
    localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int AW = $clog2(N_JOBS);

    typedef struct packed {
        logic [CW-1:0]       core;
        logic [ID_WIDTH-1:0] id;
    } job_t;

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t              state_q, state_d;
    job_t                mem_q [N_JOBS];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         cnt_q, cnt_d;
    logic [CW-1:0]       rr_q, rr_d;
    logic [ID_WIDTH-1:0] id_q;
    job_t                cur_q;
    job_t                head;
    logic                empty, full, push, pop, show_head;
    logic [N_CORES-1:0]  gnt;
    logic [CW-1:0]       winner;
    logic [CW:0]         sel;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(N_JOBS));
    assign head  = mem_q[rd_ptr_q];

    // Scan from the highest offset down so the requester closest to rr_q wins.
    always_comb begin
        gnt    = '0;
        winner = '0;
        sel    = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            sel = {1'b0, rr_q} + (CW+1)'(k);
            if (sel >= (CW+1)'(N_CORES)) begin
                sel = sel - (CW+1)'(N_CORES);
            end
            if (bus.req_i[sel[CW-1:0]]) begin
                winner = sel[CW-1:0];
            end
        end
        if (rst_ni && !clear_i && !full && (bus.req_i != '0)) begin
            gnt[winner] = 1'b1;
        end
    end

    assign rr_d = (winner == CW'(N_CORES - 1)) ? '0 : winner + 1'b1;
    assign push = (gnt != '0);
    assign pop  = (state_q == START) && bus.start_ready_i && !clear_i;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

`ifdef MAC_JOB_DISPATCHER_WATCHDOG_EN
    logic [31:0] wdt_q;
    logic        wdt_hit;

    assign wdt_hit = (bus.wdt_limit_i != '0) && (wdt_q == bus.wdt_limit_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdt_q <= '0;
        end else if (clear_i || pop) begin
            wdt_q <= '0;
        end else if (state_q == RUN) begin
            wdt_q <= wdt_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus.start_o = 1'b0;
        bus.evt_o   = '0;
`ifdef MAC_JOB_DISPATCHER_WATCHDOG_EN
        bus.abort_o = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = START;
                end
            end
            START: begin
                bus.start_o = 1'b1;
                if (bus.start_ready_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.done_i) begin
                    state_d = DONE;
                end
`ifdef MAC_JOB_DISPATCHER_WATCHDOG_EN
                else if (wdt_hit) begin
                    bus.abort_o = 1'b1;
                    state_d     = DONE;
                end
`endif
            end
            DONE: begin
                bus.evt_o[cur_q.core] = 1'b1;
                state_d               = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
        end
    end

    // Queue storage needs no reset: entries are only read when the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{core: winner, id: id_q};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rr_q     <= '0;
            id_q     <= '0;
            cur_q    <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rr_q     <= '0;
            id_q     <= '0;
            cur_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                rr_q     <= rr_d;
                id_q     <= id_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                cur_q    <= head;
            end
        end
    end

    assign show_head      = (state_q == START) || ((state_q == IDLE) && !empty);
    assign bus.gnt_o      = gnt;
    assign bus.job_id_o   = id_q;
    assign bus.cur_core_o = show_head ? head.core : cur_q.core;
    assign bus.cur_id_o   = show_head ? head.id : cur_q.id;
    assign bus.busy_o     = (state_q != IDLE) || !empty;
    assign bus.full_o     = full;

endmodule

// File: doc/mac_job_dispatcher.md
MAC_JOB_DISPATCHER -- requirements
Module: mac_job_dispatcher

Interface
REQ-001 Parameter N_CORES, default 2: number of requesting cores.
REQ-002 Parameter N_JOBS, default 2: pending-job queue depth; power of two, at least 2.
REQ-003 Parameter ID_WIDTH, default 8: job identifier width.
REQ-004 Port clk_i, input, 1: single clock; all state on its rising edge.
REQ-005 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-006 Port clear_i, input, 1: synchronous soft clear.
REQ-007 Port req_i, input, N_CORES: level job request, one bit per core.
REQ-008 Port gnt_o, output, N_CORES: one-hot acceptance pulse.
REQ-009 Port job_id_o, output, ID_WIDTH: ID assigned to the granted job; valid while gnt_o is non-zero.
REQ-010 Port start_o, output, 1: job start request to the MAC FSM.
REQ-011 Port start_ready_i, input, 1: FSM accepts the start.
REQ-012 Port cur_core_o, output, $clog2(N_CORES): owner of the head or running job.
REQ-013 Port cur_id_o, output, ID_WIDTH: ID of the head or running job.
REQ-014 Port done_i, input, 1: single-cycle engine completion.
REQ-015 Port evt_o, output, N_CORES: one-cycle completion event to the owning core.
REQ-016 Port busy_o, output, 1: FSM not in IDLE, or queue non-empty.
REQ-017 Port full_o, output, 1: queue holds N_JOBS entries.
REQ-018 Port wdt_limit_i, input, 32: watchdog limit; present only with the macro defined.
REQ-019 Port abort_o, output, 1: watchdog abort pulse; present only with the macro defined.

Function
REQ-020 Arbitration: gnt_o is combinational, round-robin over req_i, starting from pointer rr_q; it is zero when the registered full_o is 1, even if a pop occurs that cycle.
REQ-021 After each grant, rr_q becomes (winner+1) mod N_CORES; one grant at most per cycle.
REQ-022 Job ID counter: job_id_o equals id_q; id_q increments on each grant and wraps from 2^ID_WIDTH-1 to 0.
REQ-023 Queue: a FIFO of {core, id} entries; push on grant, visible at the head the next cycle; pop on the start_o and start_ready_i handshake.
REQ-024 FSM states are IDLE, START, RUN and DONE.
REQ-025 IDLE transitions to START in the cycle after the queue becomes non-empty.
REQ-026 In START, start_o is 1 and cur_core_o/cur_id_o show the queue head; these hold stable until start_ready_i; on the handshake the FSM pops and moves to RUN.
REQ-027 RUN latches the popped core and ID onto cur_core_o/cur_id_o; on done_i it moves to DONE.
REQ-028 DONE asserts evt_o[cur_core] for exactly one cycle, then returns to IDLE.
REQ-029 Latency: a grant in cycle 0 gives START and start_o in cycle 2 when idle and the queue was empty.
REQ-030 done_i outside RUN is ignored, and req_i held high re-requests every cycle it is eligible.
REQ-031 Simultaneous grant and pop when not full both take effect; the queue count is unchanged.
REQ-032 clear_i takes priority over all other inputs: it flushes the queue, sets the FSM to IDLE and zeroes rr_q, id_q and the watchdog; no evt_o fires for flushed jobs.

Reset
REQ-033 While rst_ni is 0: FSM=IDLE, queue empty, rr_q=0, id_q=0, watchdog=0.
REQ-034 While rst_ni is 0, all outputs are 0: gnt_o, start_o, evt_o, busy_o, full_o, abort_o, cur_core_o and cur_id_o.

Configuration
REQ-035 Macro MAC_JOB_DISPATCHER_WATCHDOG_EN: when defined, a 32-bit counter clears on entry to RUN and increments each RUN cycle.
REQ-036 With the macro defined, when count==wdt_limit_i and done_i=0, abort_o pulses one cycle, the FSM goes to DONE and evt_o still fires; wdt_limit_i=0 disables the watchdog.
REQ-037 With the macro undefined, the counter, wdt_limit_i and abort_o are absent, and RUN waits for done_i indefinitely.

Verification
REQ-038 Single job: N_CORES=2; req_i=01 for one cycle, start_ready_i=1, done_i 5 cycles after RUN -> gnt_o=01 and job_id_o=0; start_o in cycle 2; evt_o=01 one cycle after done_i.
REQ-039 Round-robin: req_i=11 held -> gnt_o sequence 01,10,01,10 until full_o=1, then gnt_o=00; job IDs 0,1,...
REQ-040 Backpressure: start_ready_i=0 for 10 cycles -> start_o, cur_core_o and cur_id_o stable; no pop; RUN only after ready rises.
REQ-041 Clear: clear_i pulsed in RUN with 2 jobs queued -> next cycle IDLE, full_o=0, busy_o=0; no evt_o; next grant carries ID 0.
REQ-042 ID wrap: ID_WIDTH=2, 5 jobs -> job_id_o sequence 0,1,2,3,0.
REQ-043 Watchdog (macro defined): wdt_limit_i=8, done_i never asserted -> abort_o pulses 8 cycles after RUN entry, evt_o fires, FSM returns to IDLE.
